plic_lite: RTL

- Parametrised platform-level interrupt controller. Replaces the single-source, hard-wired key interrupt latch in the board top.
- Accepts NUM_SRC external sources, each level- or edge-triggered, with per-source priority, enable mask, global threshold, and a claim/complete gateway.
- Drives one machine-external interrupt line plus the winning ID to the core.
- Software-visible through the core's existing 64-bit bus; the board top supplies a chip-select from its address decode.

---
 rtl/plic_lite_if.sv | 27 ++
 rtl/plic_lite.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/plic_lite_if.sv
// Bus window for plic_lite: chip-select, byte offset, write and read paths.
interface plic_lite_if;
  logic        sel;
  logic [7:0]  bus_address;
  logic [63:0] bus_write_data;
  logic        bus_write_enable;
  logic        bus_read_enable;
  logic [63:0] bus_read_data;

  modport master (
    output sel,
    output bus_address,
    output bus_write_data,
    output bus_write_enable,
    output bus_read_enable,
    input  bus_read_data
  );

  modport slave (
    input  sel,
    input  bus_address,
    input  bus_write_data,
    input  bus_write_enable,
    input  bus_read_enable,
    output bus_read_data
  );
endinterface

// File: rtl/plic_lite.sv
// Lightweight platform-level interrupt controller: per-source gateway (level or rising edge),
// priority/enable/threshold arbitration and a claim/complete handshake over a 64-bit bus.
module plic_lite #(
  parameter int unsigned        NUM_SRC     = 8,
  parameter int unsigned        PRIO_W      = 3,
  parameter logic [NUM_SRC-1:0] EDGE_MASK   = '0,
  parameter int unsigned        SYNC_STAGES = 2,
  parameter int unsigned        ID_W        = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] irq_src,
  plic_lite_if.slave         bus,
  output logic               irq_out,
  output logic [ID_W-1:0]    irq_id
);

  localparam logic [4:0] WordPending   = 5'd0;
  localparam logic [4:0] WordEnable    = 5'd1;
  localparam logic [4:0] WordThreshold = 5'd2;
  localparam logic [4:0] WordClaim     = 5'd3;
  // PRIORITY[k] lives at word 8+k; with an 8-bit window only k < 24 is reachable.
  localparam int         WordPrioBase  = 8;

  // ---------------------------------------------------------------------------
  // Input synchroniser
  // ---------------------------------------------------------------------------
  logic [NUM_SRC-1:0] src_s;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign src_s = irq_src;
    end else begin : g_sync
      logic [NUM_SRC-1:0] sync_q [SYNC_STAGES];

      // Shift raw requests through SYNC_STAGES flops.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int i = 0; i < int'(SYNC_STAGES); i++) sync_q[i] <= '0;
        end else begin
          sync_q[0] <= irq_src;
          for (int i = 1; i < int'(SYNC_STAGES); i++) sync_q[i] <= sync_q[i-1];
        end
      end

      assign src_s = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [NUM_SRC-1:0] pending_q, pending_d;
  logic [NUM_SRC-1:0] in_service_q, in_service_d;
  logic [NUM_SRC-1:0] deferred_q, deferred_d;
  logic [NUM_SRC-1:0] src_prev_q;
  logic [NUM_SRC-1:0] enable_q;
  logic [PRIO_W-1:0]  threshold_q;
  logic [PRIO_W-1:0]  prio_q [NUM_SRC];
  logic               rd_prev_q, wr_prev_q;
  logic [63:0]        rdata_q, rdata_d;
  logic               irq_out_q;
  logic [ID_W-1:0]    irq_id_q;

  // ---------------------------------------------------------------------------
  // Bus strobes and decode
  // ---------------------------------------------------------------------------
  logic       rd_act, wr_act, rd_fire, wr_fire;
  logic [4:0] word;
  logic [ID_W-1:0] cmp_id;

  assign rd_act  = bus.sel & bus.bus_read_enable;
  assign wr_act  = bus.sel & bus.bus_write_enable;
  // Side-effects only on the first cycle of a held strobe.
  assign rd_fire = rd_act & ~rd_prev_q;
  assign wr_fire = wr_act & ~wr_prev_q;
  assign word    = bus.bus_address[7:3];
  assign cmp_id  = bus.bus_write_data[ID_W-1:0];

  logic unused_bus_bits;
  assign unused_bus_bits = ^{bus.bus_address[2:0], bus.bus_write_data};

  // ---------------------------------------------------------------------------
  // Eligibility and arbitration
  // ---------------------------------------------------------------------------
  logic [NUM_SRC-1:0] eligible;
  logic [ID_W-1:0]    win_id;
  logic [PRIO_W-1:0]  win_prio;

  // Highest priority wins; strict compare keeps the lowest ID on ties.
  always_comb begin
    eligible = '0;
    win_id   = '0;
    win_prio = '0;
    for (int k = 0; k < int'(NUM_SRC); k++) begin
      eligible[k] = pending_q[k] & enable_q[k] & (prio_q[k] > threshold_q);
      if (eligible[k] && (prio_q[k] > win_prio)) begin
        win_id   = ID_W'(k + 1);
        win_prio = prio_q[k];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Gateway next state
  // ---------------------------------------------------------------------------
  logic               claim_fire;
  logic [NUM_SRC-1:0] claim_mask, cmp_mask;
  logic [NUM_SRC-1:0] rise, set_now, defer_set, defer_move;

  assign claim_fire = rd_fire && (word == WordClaim) && (win_id != '0);

  // Decode the claim winner and a valid complete into per-source masks.
  always_comb begin
    claim_mask = '0;
    cmp_mask   = '0;
    for (int k = 0; k < int'(NUM_SRC); k++) begin
      claim_mask[k] = claim_fire && (win_id == ID_W'(k + 1));
      cmp_mask[k]   = wr_fire && (word == WordClaim) && (cmp_id == ID_W'(k + 1))
                      && in_service_q[k];
    end
  end

  // Edges during service collapse into deferred, released once service ends.
  always_comb begin
    rise         = src_s & ~src_prev_q;
    set_now      = ~in_service_q & ((EDGE_MASK & rise) | (~EDGE_MASK & src_s));
    defer_set    = in_service_q & EDGE_MASK & rise;
    defer_move   = deferred_q & ~in_service_q;
    pending_d    = (pending_q | set_now | defer_move) & ~claim_mask;
    deferred_d   = (deferred_q & ~defer_move) | defer_set;
    in_service_d = (in_service_q | claim_mask) & ~cmp_mask;
  end

  // Gateway and handshake state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_q    <= '0;
      in_service_q <= '0;
      deferred_q   <= '0;
      src_prev_q   <= '0;
      rd_prev_q    <= 1'b0;
      wr_prev_q    <= 1'b0;
    end else begin
      pending_q    <= pending_d;
      in_service_q <= in_service_d;
      deferred_q   <= deferred_d;
      src_prev_q   <= src_s;
      rd_prev_q    <= rd_act;
      wr_prev_q    <= wr_act;
    end
  end

  // ---------------------------------------------------------------------------
  // Configuration registers
  // ---------------------------------------------------------------------------
  // Software writes to ENABLE, THRESHOLD and PRIORITY, truncated to field width.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enable_q    <= '0;
      threshold_q <= '0;
      for (int k = 0; k < int'(NUM_SRC); k++) prio_q[k] <= '0;
    end else if (wr_fire) begin
      if (word == WordEnable)    enable_q    <= bus.bus_write_data[NUM_SRC-1:0];
      if (word == WordThreshold) threshold_q <= bus.bus_write_data[PRIO_W-1:0];
      for (int k = 0; k < int'(NUM_SRC); k++) begin
        if (int'(word) == k + WordPrioBase) prio_q[k] <= bus.bus_write_data[PRIO_W-1:0];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------------
  logic [63:0] rd_mux;

  // Select the pre-write value of the addressed register.
  always_comb begin
    rd_mux = '0;
    case (word)
      WordPending:   rd_mux[NUM_SRC-1:0] = pending_q;
      WordEnable:    rd_mux[NUM_SRC-1:0] = enable_q;
      WordThreshold: rd_mux[PRIO_W-1:0]  = threshold_q;
      WordClaim:     rd_mux[ID_W-1:0]    = win_id;
      default: begin
        for (int k = 0; k < int'(NUM_SRC); k++) begin
          if (int'(word) == k + WordPrioBase) rd_mux[PRIO_W-1:0] = prio_q[k];
        end
      end
    endcase
  end

  // Capture on the first strobe cycle, hold while held, zero otherwise.
  always_comb begin
    rdata_d = '0;
    if (rd_fire)     rdata_d = rd_mux;
    else if (rd_act) rdata_d = rdata_q;
  end

  // Registered read data and interrupt outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_q   <= '0;
      irq_out_q <= 1'b0;
      irq_id_q  <= '0;
    end else begin
      rdata_q   <= rdata_d;
      irq_out_q <= (win_id != '0);
      irq_id_q  <= win_id;
    end
  end

  assign bus.bus_read_data = rdata_q;
  assign irq_out           = irq_out_q;
  assign irq_id            = irq_id_q;

endmodule
